next_hop_table: RTL and testbench

- Parametrised next-hop lookup table and successor to the fixed 8 KB, 4-lane byte-writable next-hop RAM.
- Width, depth and lane size are parameters.
- A self-clearing init sequencer replaces file-based preload.
- Ports:
  - host port: CPU-side, byte-lane writes and reads;
  - lookup port: forwarding-path, pipelined one lookup per cycle, valid-only handshake.
- Sits between the packet-processing core (lookups) and the management processor (table updates).

---
 rtl/next_hop_table.sv | 152 +++++++++++++++
 tb/tb_next_hop_table.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/next_hop_table.sv
// Next-hop lookup table: host byte-lane read/write port, fixed-latency lookup
// port, and a self-clearing init sweep that fills every entry with INIT_VAL.
//
// state | meaning
// INIT  | sweep writes INIT_VAL to r_cnt each cycle; host and lookups ignored
// RUN   | host and lookup ports live; i_init_start re-enters INIT
module next_hop_table #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int LANE_W = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_init_start,
  output logic                       o_init_busy,
  input  logic                       i_host_en,
  input  logic [DATA_W/LANE_W-1:0]   i_host_we,
  input  logic [ADDR_W-1:0]          i_host_addr,
  input  logic [DATA_W-1:0]          i_host_wdata,
  output logic [DATA_W-1:0]          o_host_rdata,
  output logic                       o_host_rvalid,
  input  logic                       i_lk_req,
  input  logic [ADDR_W-1:0]          i_lk_addr,
  output logic                       o_lk_ready,
  output logic                       o_lk_valid,
  output logic [DATA_W-1:0]          o_lk_data
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int LANES = DATA_W / LANE_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt, w_cnt_nxt;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                r_s1_valid;
  logic [DATA_W-1:0]   r_s1_data;
  logic                r_lk_valid;
  logic [DATA_W-1:0]   r_lk_data;
  logic                r_host_rvalid;
  logic [DATA_W-1:0]   r_host_rdata;

  logic                w_run;
  logic                w_host_wr;
  logic                w_host_rd;
  logic                w_lk_acc;
  logic [LANES-1:0]    w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic [DATA_W-1:0]   w_lk_rd;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_INIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (&r_cnt) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        if (i_init_start) begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_run     = (r_state == ST_RUN);
  assign w_host_wr = w_run && i_host_en && (|i_host_we);
  assign w_host_rd = w_run && i_host_en && !(|i_host_we);
  assign w_lk_acc  = w_run && i_lk_req;

  // The sweep and the host share the single write port; they never overlap.
  always_comb begin
    if (w_run) begin
      w_mem_we    = w_host_wr ? i_host_we : '0;
      w_mem_addr  = i_host_addr;
      w_mem_wdata = i_host_wdata;
    end else begin
      w_mem_we    = '1;
      w_mem_addr  = r_cnt;
      w_mem_wdata = INIT_VAL;
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (w_mem_we[i])
        r_mem[w_mem_addr][i*LANE_W +: LANE_W] <= w_mem_wdata[i*LANE_W +: LANE_W];
    end
  end

  // Write-first bypass: lanes written this cycle to the lookup address win.
  always_comb begin
    w_lk_rd = r_mem[i_lk_addr];
    for (int i = 0; i < LANES; i++) begin
      if (w_host_wr && i_host_we[i] && (i_host_addr == i_lk_addr))
        w_lk_rd[i*LANE_W +: LANE_W] = i_host_wdata[i*LANE_W +: LANE_W];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s1_valid    <= 1'b0;
      r_s1_data     <= '0;
      r_lk_valid    <= 1'b0;
      r_lk_data     <= '0;
      r_host_rvalid <= 1'b0;
      r_host_rdata  <= '0;
    end else begin
      r_s1_valid    <= w_lk_acc;
      r_lk_valid    <= r_s1_valid;
      r_host_rvalid <= w_host_rd;
      if (w_lk_acc)
        r_s1_data <= w_lk_rd;
      if (r_s1_valid)
        r_lk_data <= r_s1_data;
      if (w_host_rd)
        r_host_rdata <= r_mem[i_host_addr];
    end
  end

  assign o_init_busy   = !w_run;
  assign o_lk_ready    = w_run;
  assign o_lk_valid    = r_lk_valid;
  assign o_lk_data     = r_lk_data;
  assign o_host_rvalid = r_host_rvalid;
  assign o_host_rdata  = r_host_rdata;

endmodule

// File: tb/tb_next_hop_table.sv
// Bench for next_hop_table: directed scenarios plus a randomized host/lookup
// mix checked against an array model of the table.
module tb_next_hop_table;

  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_start;
  logic          init_busy;
  logic          host_en;
  logic [3:0]    host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;
  logic          lk_req;
  logic [AW-1:0] lk_addr;
  logic          lk_ready;
  logic          lk_valid;
  logic [DW-1:0] lk_data;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [DEPTH];

  always #5 clk = ~clk;

  next_hop_table #(.ADDR_W(AW), .DATA_W(DW), .LANE_W(8), .INIT_VAL(32'h0)) dut (
    .i_clk(clk), .i_reset(rst), .i_init_start(init_start), .o_init_busy(init_busy),
    .i_host_en(host_en), .i_host_we(host_we), .i_host_addr(host_addr),
    .i_host_wdata(host_wdata), .o_host_rdata(host_rdata), .o_host_rvalid(host_rvalid),
    .i_lk_req(lk_req), .i_lk_addr(lk_addr), .o_lk_ready(lk_ready),
    .o_lk_valid(lk_valid), .o_lk_data(lk_data)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (we[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endtask

  task automatic idle();
    init_start = 1'b0; host_en = 1'b0; host_we = 4'h0; host_addr = '0;
    host_wdata = '0; lk_req = 1'b0; lk_addr = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Counts cycles while init_busy is high, plus any output pulses seen.
  task automatic wait_sweep(output int n, output int lkv, output int rv);
    n = 0; lkv = 0; rv = 0;
    while (init_busy && n < 5000) begin
      step();
      n++;
      if (lk_valid) lkv++;
      if (host_rvalid) rv++;
    end
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] we);
    host_en = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    step();
    idle();
    model[a] = merge(model[a], d, we);
  endtask

  task automatic host_read_check(input logic [AW-1:0] a, input logic [31:0] exp);
    host_en = 1'b1; host_we = 4'h0; host_addr = a;
    step();
    idle();
    checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== exp) begin
      errors++;
      $display("FAIL host_read addr %h: rvalid %b data %h, want rvalid 1 data %h", a, host_rvalid, host_rdata, exp);
    end
    step();
    checks++;
    if (host_rvalid !== 1'b0 || host_rdata !== exp) begin
      errors++;
      $display("FAIL host_read_hold addr %h: rvalid %b data %h, want rvalid 0 data %h", a, host_rvalid, host_rdata, exp);
    end
  endtask

  task automatic lookup_check(input logic [AW-1:0] a, input logic [31:0] exp);
    lk_req = 1'b1; lk_addr = a;
    step();
    idle();
    checks++;
    if (lk_valid !== 1'b0) begin
      errors++;
      $display("FAIL lookup_early addr %h: lk_valid %b at N+1, want 0", a, lk_valid);
    end
    step();
    checks++;
    if (lk_valid !== 1'b1 || lk_data !== exp) begin
      errors++;
      $display("FAIL lookup addr %h: valid %b data %h, want valid 1 data %h", a, lk_valid, lk_data, exp);
    end
    step();
    checks++;
    if (lk_valid !== 1'b0 || lk_data !== exp) begin
      errors++;
      $display("FAIL lookup_hold addr %h: valid %b data %h, want valid 0 data %h", a, lk_valid, lk_data, exp);
    end
  endtask

  task automatic test_reset();
    int n, lkv, rv;
    rst = 1'b1;
    idle();
    repeat (3) step();
    checks++;
    if (init_busy !== 1'b1 || lk_ready !== 1'b0 || lk_valid !== 1'b0 || host_rvalid !== 1'b0 ||
        host_rdata !== 32'h0 || lk_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: busy %b ready %b lkv %b rv %b rdata %h lkd %h, want 1 0 0 0 0 0",
               init_busy, lk_ready, lk_valid, host_rvalid, host_rdata, lk_data);
    end
    rst = 1'b0;
    wait_sweep(n, lkv, rv);
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL reset_sweep_len: got %0d cycles, want %0d", n, DEPTH);
    end
    checks++;
    if (lk_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_sweep: got %b want 1", lk_ready);
    end
    clear_model();
  endtask

  task automatic test_lookup_boundary();
    lookup_check(11'h7FF, 32'h0000_0000);
  endtask

  task automatic test_host_lanes();
    host_write(11'h010, 32'hDEADBEEF, 4'b1111);
    host_write(11'h010, 32'h11223344, 4'b0101);
    host_read_check(11'h010, 32'hDE22BE44);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) host_write(11'(16 + k), $urandom, 4'hF);
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin lk_req = 1'b1; lk_addr = 11'(16 + k); end
      else idle();
      step();
      checks++;
      if (k >= 1 && k <= 3) begin
        if (lk_valid !== 1'b1 || lk_data !== model[16 + k - 1]) begin
          errors++;
          $display("FAIL b2b slot %0d: valid %b data %h, want 1 %h", k, lk_valid, lk_data, model[16 + k - 1]);
        end
      end else if (lk_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b slot %0d: valid %b, want 0", k, lk_valid);
      end
    end
    idle();
  endtask

  task automatic test_rdw();
    host_write(11'h020, 32'h12345678, 4'hF);
    host_en = 1'b1; host_we = 4'b0011; host_addr = 11'h020; host_wdata = 32'hCAFEF00D;
    lk_req = 1'b1; lk_addr = 11'h020;
    step();
    idle();
    model[11'h020] = merge(model[11'h020], 32'hCAFEF00D, 4'b0011);
    step();
    checks++;
    if (lk_valid !== 1'b1 || lk_data !== 32'h1234F00D) begin
      errors++;
      $display("FAIL rdw_lookup: valid %b data %h, want 1 1234f00d", lk_valid, lk_data);
    end
    step();
    host_read_check(11'h020, 32'h1234F00D);
  endtask

  task automatic test_random();
    logic [31:0] q_lk_d[$];
    int          q_lk_t[$];
    logic [31:0] q_h_d[$];
    int          q_h_t[$];
    int op;
    logic [3:0]  we;
    logic [31:0] wd, exp;
    logic [AW-1:0] ha, la;
    for (int c = 0; c < 403; c++) begin
      exp = 32'h0;
      checks++;
      if (q_lk_t.size() > 0 && q_lk_t[0] == c) begin
        exp = q_lk_d.pop_front();
        void'(q_lk_t.pop_front());
        if (lk_valid !== 1'b1 || lk_data !== exp) begin
          errors++;
          $display("FAIL rand_lookup cyc %0d: valid %b data %h, want 1 %h", c, lk_valid, lk_data, exp);
        end
      end else if (lk_valid !== 1'b0) begin
        errors++;
        $display("FAIL rand_lookup cyc %0d: valid %b, want 0", c, lk_valid);
      end
      checks++;
      if (q_h_t.size() > 0 && q_h_t[0] == c) begin
        exp = q_h_d.pop_front();
        void'(q_h_t.pop_front());
        if (host_rvalid !== 1'b1 || host_rdata !== exp) begin
          errors++;
          $display("FAIL rand_host cyc %0d: rvalid %b data %h, want 1 %h", c, host_rvalid, host_rdata, exp);
        end
      end else if (host_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL rand_host cyc %0d: rvalid %b, want 0", c, host_rvalid);
      end
      idle();
      if (c < 400) begin
        op = $urandom_range(0, 2);
        ha = 11'($urandom_range(0, 15));
        la = 11'($urandom_range(0, 15));
        wd = $urandom;
        we = (op == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        if (op != 0) begin host_en = 1'b1; host_we = we; host_addr = ha; host_wdata = wd; end
        if (op == 2) begin q_h_d.push_back(model[ha]); q_h_t.push_back(c + 1); end
        if ($urandom_range(0, 3) != 0) begin
          lk_req = 1'b1; lk_addr = la;
          q_lk_d.push_back((op == 1 && ha == la) ? merge(model[la], wd, we) : model[la]);
          q_lk_t.push_back(c + 2);
        end
        if (op == 1) model[ha] = merge(model[ha], wd, we);
      end
      step();
    end
    idle();
  endtask

  task automatic test_init_start();
    logic [31:0] v;
    int n, lkv, rv;
    logic [31:0] got;
    v = $urandom | 32'h1;
    host_write(11'h030, v, 4'hF);
    init_start = 1'b1; lk_req = 1'b1; lk_addr = 11'h030;
    step();
    idle();
    checks++;
    if (init_busy !== 1'b1 || lk_ready !== 1'b0) begin
      errors++;
      $display("FAIL init_entry: busy %b ready %b, want 1 0", init_busy, lk_ready);
    end
    n = 0; lkv = 0; rv = 0; got = 32'h0;
    while (init_busy && n < 5000) begin
      idle();
      if (n == 100) begin
        host_en = 1'b1; host_we = 4'hF; host_addr = 11'h005; host_wdata = 32'hA5A5A5A5;
        lk_req = 1'b1; lk_addr = 11'h005;
      end
      if (n == 101) begin host_en = 1'b1; host_addr = 11'h030; lk_req = 1'b1; end
      step();
      n++;
      if (lk_valid) begin lkv++; got = lk_data; end
      if (host_rvalid) rv++;
    end
    idle();
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL init_sweep_len: got %0d cycles, want %0d", n, DEPTH);
    end
    checks++;
    if (lkv != 1 || got !== v) begin
      errors++;
      $display("FAIL init_preclear_lookup: %0d pulses data %h, want 1 pulse data %h", lkv, got, v);
    end
    checks++;
    if (rv != 0) begin
      errors++;
      $display("FAIL init_host_ignored: %0d rvalid pulses, want 0", rv);
    end
    clear_model();
    host_read_check(11'h030, 32'h0);
    host_read_check(11'h005, 32'h0);
    lookup_check(11'h030, 32'h0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] x;
    int n, lkv, rv;
    x = $urandom | 32'h8000_0001;
    host_write(11'h040, x, 4'hF);
    lookup_check(11'h040, x);
    host_read_check(11'h040, x);
    lk_req = 1'b1; lk_addr = 11'h040;
    step();
    idle();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (init_busy !== 1'b1 || lk_ready !== 1'b0 || lk_valid !== 1'b0 || host_rvalid !== 1'b0 ||
        host_rdata !== 32'h0 || lk_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_inflight: busy %b ready %b lkv %b rv %b rdata %h lkd %h, want 1 0 0 0 0 0",
               init_busy, lk_ready, lk_valid, host_rvalid, host_rdata, lk_data);
    end
    step(); step();
    rst = 1'b0;
    n = 0;
    lkv = 0;
    while (n < 500) begin
      step();
      n++;
      if (lk_valid) lkv++;
    end
    checks++;
    if (lkv != 0 || init_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_stale: %0d lk_valid pulses busy %b, want 0 pulses busy 1", lkv, init_busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (init_busy !== 1'b1 || lk_ready !== 1'b0 || lk_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_midsweep: busy %b ready %b lkv %b, want 1 0 0", init_busy, lk_ready, lk_valid);
    end
    step();
    rst = 1'b0;
    wait_sweep(n, lkv, rv);
    checks++;
    if (n != DEPTH || lkv != 0 || rv != 0) begin
      errors++;
      $display("FAIL reset_resweep: %0d cycles %0d lkv %0d rv, want %0d 0 0", n, lkv, rv, DEPTH);
    end
    clear_model();
    host_read_check(11'h040, 32'h0);
  endtask

  initial begin
    test_reset();
    test_lookup_boundary();
    test_host_lanes();
    test_back_to_back();
    test_rdw();
    test_random();
    test_init_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
